tlb_inv_walker: RTL and testbench
=================================

Name: tlb_inv_walker

Overview:
- Executes the INVTLB operation for the TLB: the removal side, complementing TLBWR/TLBFILL, which install entries.
- Accepts one committed invalidate request from the WB stage.
- Walks all TLBNUM entries, one per cycle, over the TLB's compare-item read port.
- Clears the E bit of every entry that matches the op-selected predicate, then reports completion, or reports an invalid op for INE.

Parameters:
- TLBNUM, 16, number of TLB entries; TLBNUMSIZE = $clog2(TLBNUM), the index width.

Ports:
- aclk  in  1  clock.
- areset  in  1  asynchronous reset, active-high.
- req_valid  in  1  invalidate request from WB.
- req_ready  out  1  walker can accept a request.
- req_op  in  3  INVTLB op: CLEAR_ALL0 … CLEAR_G1_OR_ASID_AND_VA (0–6).
- req_asid  in  10  ASID operand (rj[9:0]).
- req_va  in  32  VA operand (rk).
- rd_idx  out  TLBNUMSIZE  TLB compare-item read index.
- rd_ci  in  37  CompareItem {E, ASID[9:0], G, PS[5:0], VPPN[18:0]} at rd_idx, combinational read.
- clr_en  out  1  clear E of entry clr_idx at the next aclk edge.
- clr_idx  out  TLBNUMSIZE  entry to clear.
- busy  out  1  walk in progress.
- done  out  1  one-cycle completion pulse.
- err_ine  out  1  one-cycle pulse with done: op was invalid.
- clr_count  out  TLBNUMSIZE+1  number of entries cleared by the last walk; held until the next accept.

Behaviour:
- Reset (async, areset=1):
  - state=IDLE, idx=0.
  - req_ready=1; busy, done, err_ine, clr_en = 0.
  - rd_idx=0, clr_idx=0, clr_count=0.
- States:
  - IDLE: req_ready=1.
  - WALK: busy=1, req_ready=0.
  - FIN: done=1, req_ready=0.
- Accept: a handshake occurs when req_valid && req_ready at an aclk edge.
  - Latch op, asid, and va[31:13] as vppn.
  - Clear clr_count; set idx=0.
- Transitions on accept:
  - op ≤ 6 → WALK.
  - op = 7 → FIN with err_ine=1 for that FIN cycle; no entries are touched.
- WALK, each cycle:
  - rd_idx=idx.
  - Evaluate the predicate on rd_ci.
  - clr_en = predicate && rd_ci.E; clr_idx=idx.
  - If clr_en: clr_count+1.
  - If idx = TLBNUM-1 → FIN, otherwise idx+1.
- Predicates (G, ASID, PS, VPPN from rd_ci):
  - op 0/1: always true.
  - op 2: G=1.
  - op 3: G=0.
  - op 4: G=0 && ASID=asid.
  - op 5: G=0 && ASID=asid && vamatch.
  - op 6: (G=1 || ASID=asid) && vamatch.
- vamatch:
  - PS=12: VPPN[18:0] = vppn[18:0].
  - Any other PS (21): VPPN[18:9] = vppn[18:9], i.e. va[31:22].
- Entries with E=0 never assert clr_en, even if the predicate matches. clr_count therefore counts only real clears.
- FIN lasts one cycle: done=1, then → IDLE with req_ready=1 on the next cycle.
  - A back-to-back request is accepted no earlier than the cycle after done.
- Latency for a valid op:
  - Accept at edge T.
  - WALK cycles T+1 … T+TLBNUM.
  - done high in cycle T+TLBNUM+1.
  - Minimum request-to-request spacing is TLBNUM+2 cycles.
- Latency for an invalid op: done and err_ine are high in cycle T+1.
- req_valid while busy: ignored (req_ready=0). The requester must hold req_valid until accepted.
- The latched operands are stable through the walk; changes on req_* during WALK have no effect.
- areset mid-walk: abort immediately to the reset values.
  - Entries already cleared stay cleared.
  - No done pulse is produced for the aborted request.
- Write/read collision: a clear issued in cycle k takes effect at the edge ending cycle k.
  - The walker never re-reads a lower index, so no hazard exists inside a walk.
- clr_en is 0 in every state except WALK; rd_idx holds its last value outside WALK.

Test Plan:
1. Reset, then op=0 with all 16 entries E=1 → clr_en high for 16 consecutive cycles, clr_idx 0…15; done at T+17; clr_count=16; err_ine=0.
2. Entries 3 and 9 with G=1, the rest G=0, all E=1; op=2 → clr_en only at idx 3 and 9; clr_count=2.
3. op=5, asid=0x2A, va=0x1234_5000; entry 4 {G=0, ASID=0x2A, PS=12, VPPN=0x091A2} and entry 7 with the same fields but ASID=0x2B → only entry 4 cleared; clr_count=1.
4. op=6, va=0x00C0_0000; entry 1 {G=1, PS=21, VPPN[18:9]=0x003, VPPN[8:0]=0x1FF}; entry 2 {E=0, otherwise matching} → entry 1 cleared, entry 2 not; clr_count=1.
5. op=7 → done=1 and err_ine=1 at T+1; clr_en never asserted; clr_count=0.
6. Assert areset at WALK idx=5 → next cycle busy=0, req_ready=1, no done pulse. Then a new op=0 request completes normally with clr_count=16; a second request held during busy is accepted exactly one cycle after done.

Source files
------------

// File: rtl/tlb_inv_walker_if.sv
// Request handshake and TLB compare-item read / E-clear port of the INVTLB walker.
interface tlb_inv_walker_if #(
  parameter int TLBNUM = 16
);
  localparam int TLBNUMSIZE = $clog2(TLBNUM);

  logic                  req_valid;
  logic                  req_ready;
  logic [2:0]            req_op;
  logic [9:0]            req_asid;
  logic [31:0]           req_va;
  logic [TLBNUMSIZE-1:0] rd_idx;
  logic [36:0]           rd_ci;
  logic                  clr_en;
  logic [TLBNUMSIZE-1:0] clr_idx;
  logic                  busy;
  logic                  done;
  logic                  err_ine;
  logic [TLBNUMSIZE:0]   clr_count;

  // walker side
  modport slave (
    input  req_valid, req_op, req_asid, req_va, rd_ci,
    output req_ready, rd_idx, clr_en, clr_idx, busy, done, err_ine, clr_count
  );

  // requester / TLB side
  modport master (
    output req_valid, req_op, req_asid, req_va, rd_ci,
    input  req_ready, rd_idx, clr_en, clr_idx, busy, done, err_ine, clr_count
  );
endinterface

// File: rtl/tlb_inv_walker.sv
// INVTLB walker: accepts one invalidate request, scans every TLB entry once
// (one per cycle) and clears E on entries matching the op-selected predicate.
module tlb_inv_walker #(
  parameter int TLBNUM = 16
) (
  input  logic             aclk,
  input  logic             areset,
  tlb_inv_walker_if.slave  bus
);
  localparam int TLBNUMSIZE = $clog2(TLBNUM);
  localparam logic [TLBNUMSIZE-1:0] LAST_IDX = TLBNUMSIZE'(TLBNUM - 1);

  typedef enum logic [1:0] {IDLE, WALK, FIN} state_t;

  // operands captured at accept; only va[31:13] matters for matching
  typedef struct packed {
    logic [2:0]  op;
    logic [9:0]  asid;
    logic [18:0] vppn;
  } inv_req_t;

  state_t                state_q, state_d;
  inv_req_t              req_q, req_d;
  logic [TLBNUMSIZE-1:0] idx_q, idx_d;
  logic [TLBNUMSIZE:0]   cnt_q, cnt_d;
  logic                  err_q, err_d;

  logic        accept;
  logic        ci_e, ci_g;
  logic [9:0]  ci_asid;
  logic [5:0]  ci_ps;
  logic [18:0] ci_vppn;
  logic        va_match, pred, hit;
  logic        unused_va_lo;

  assign unused_va_lo = ^bus.req_va[12:0];

  assign {ci_e, ci_asid, ci_g, ci_ps, ci_vppn} = bus.rd_ci;
  assign accept = bus.req_valid && (state_q == IDLE);

  // match predicate for the entry currently on the read port
  always_comb begin
    va_match = (ci_ps == 6'd12) ? (ci_vppn == req_q.vppn)
                                : (ci_vppn[18:9] == req_q.vppn[18:9]);
    pred = 1'b0;
    case (req_q.op)
      3'd0, 3'd1: pred = 1'b1;
      3'd2:       pred = ci_g;
      3'd3:       pred = !ci_g;
      3'd4:       pred = !ci_g && (ci_asid == req_q.asid);
      3'd5:       pred = !ci_g && (ci_asid == req_q.asid) && va_match;
      3'd6:       pred = (ci_g || (ci_asid == req_q.asid)) && va_match;
      default:    pred = 1'b0;
    endcase
    // invalid entries are never "cleared" so the count reflects real work
    hit = pred && ci_e;
  end

  // state register
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (bus.req_op == 3'd7) ? FIN : WALK;
      WALK:    if (idx_q == LAST_IDX) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    bus.req_ready = (state_q == IDLE);
    bus.busy      = (state_q == WALK);
    bus.done      = (state_q == FIN);
    bus.err_ine   = (state_q == FIN) && err_q;
    bus.clr_en    = (state_q == WALK) && hit;
  end

  // index doubles as read and clear address; it holds outside WALK
  assign bus.rd_idx    = idx_q;
  assign bus.clr_idx   = idx_q;
  assign bus.clr_count = cnt_q;

  // datapath next values: operand latch, index advance, clear counter
  always_comb begin
    req_d = req_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    err_d = err_q;
    if (accept) begin
      req_d.op   = bus.req_op;
      req_d.asid = bus.req_asid;
      req_d.vppn = bus.req_va[31:13];
      idx_d      = '0;
      cnt_d      = '0;
      err_d      = (bus.req_op == 3'd7);
    end else if (state_q == WALK) begin
      if (idx_q != LAST_IDX) idx_d = idx_q + TLBNUMSIZE'(1);
      if (bus.clr_en)        cnt_d = cnt_q + (TLBNUMSIZE+1)'(1);
    end
  end

  // datapath registers
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      req_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      req_q <= req_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_tlb_inv_walker.sv
// Directed bench for tlb_inv_walker with a 16-entry TLB compare-item array.
module tb_tlb_inv_walker;
  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  tlb_inv_walker_if #(.TLBNUM(16)) ifc ();

  tlb_inv_walker #(.TLBNUM(16)) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (ifc)
  );

  // TLB image: loaded from img on ld, E cleared on clr_en at the edge
  logic [36:0] tlb [16];
  logic [36:0] img [16];
  logic        ld = 1'b0;

  always @(posedge aclk) begin
    if (ld) begin
      for (int i = 0; i < 16; i++) tlb[i] <= img[i];
    end else if (ifc.clr_en) begin
      tlb[ifc.clr_idx][36] <= 1'b0;
    end
  end

  assign ifc.rd_ci = tlb[ifc.rd_idx];

  int tests = 0;
  int failed = 0;

  function automatic logic [36:0] mk(input logic e, input logic [9:0] asid,
                                     input logic g, input logic [5:0] ps,
                                     input logic [18:0] vppn);
    return {e, asid, g, ps, vppn};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_img();
    ld = 1'b1;
    @(negedge aclk);
    ld = 1'b0;
  endtask

  // issue one request and check each walk cycle against the expected clear mask
  task automatic run_walk(input string tag, input logic [2:0] op, input logic [9:0] asid,
                          input logic [31:0] va, input logic [15:0] mask,
                          input int cnt, input logic err);
    ifc.req_op = op; ifc.req_asid = asid; ifc.req_va = va; ifc.req_valid = 1'b1;
    chk({tag, ".ready"}, 64'(ifc.req_ready), 64'd1);
    @(negedge aclk);
    ifc.req_valid = 1'b0;
    if (err) begin
      chk({tag, ".done"},  64'(ifc.done),    64'd1);
      chk({tag, ".err"},   64'(ifc.err_ine), 64'd1);
      chk({tag, ".busy"},  64'(ifc.busy),    64'd0);
      chk({tag, ".clren"}, 64'(ifc.clr_en),  64'd0);
    end else begin
      for (int i = 0; i < 16; i++) begin
        chk({tag, ".busy"},  64'(ifc.busy),    64'd1);
        chk({tag, ".rdidx"}, 64'(ifc.rd_idx),  64'(i));
        chk({tag, ".clren"}, 64'(ifc.clr_en),  64'(mask[i]));
        chk({tag, ".clridx"},64'(ifc.clr_idx), 64'(i));
        @(negedge aclk);
      end
      chk({tag, ".done"},  64'(ifc.done),    64'd1);
      chk({tag, ".err"},   64'(ifc.err_ine), 64'd0);
      chk({tag, ".clren"}, 64'(ifc.clr_en),  64'd0);
    end
    chk({tag, ".count"}, 64'(ifc.clr_count), 64'(cnt));
    @(negedge aclk);
    chk({tag, ".done_off"}, 64'(ifc.done),      64'd0);
    chk({tag, ".idle"},     64'(ifc.req_ready), 64'd1);
  endtask

  initial begin
    ifc.req_valid = 1'b0; ifc.req_op = '0; ifc.req_asid = '0; ifc.req_va = '0;
    for (int i = 0; i < 16; i++) begin img[i] = '0; tlb[i] = '0; end

    // reset values
    repeat (2) @(negedge aclk);
    chk("rst.ready", 64'(ifc.req_ready), 64'd1);
    chk("rst.busy",  64'(ifc.busy),      64'd0);
    chk("rst.done",  64'(ifc.done),      64'd0);
    chk("rst.err",   64'(ifc.err_ine),   64'd0);
    chk("rst.clren", 64'(ifc.clr_en),    64'd0);
    chk("rst.rdidx", 64'(ifc.rd_idx),    64'd0);
    chk("rst.clridx",64'(ifc.clr_idx),   64'd0);
    chk("rst.count", 64'(ifc.clr_count), 64'd0);
    areset = 1'b0;
    @(negedge aclk);

    // 1: clear all
    for (int i = 0; i < 16; i++) img[i] = mk(1'b1, 10'h0, 1'b0, 6'd12, 19'(i));
    load_img();
    run_walk("t1", 3'd0, 10'h0, 32'h0, 16'hFFFF, 16, 1'b0);
    chk("t1.tlb_e0",  64'(tlb[0][36]),  64'd0);
    chk("t1.tlb_e15", 64'(tlb[15][36]), 64'd0);

    // 2: global entries only
    for (int i = 0; i < 16; i++) img[i] = mk(1'b1, 10'h0, (i == 3 || i == 9), 6'd12, 19'(i));
    load_img();
    run_walk("t2", 3'd2, 10'h0, 32'h0, 16'h0208, 2, 1'b0);

    // 3: non-global, asid and 4K va match
    for (int i = 0; i < 16; i++) img[i] = mk(1'b1, 10'h000, 1'b0, 6'd12, 19'h091A2);
    img[4] = mk(1'b1, 10'h02A, 1'b0, 6'd12, 19'h091A2);
    img[7] = mk(1'b1, 10'h02B, 1'b0, 6'd12, 19'h091A2);
    load_img();
    run_walk("t3", 3'd5, 10'h02A, 32'h1234_5000, 16'h0010, 1, 1'b0);
    chk("t3.tlb_e7", 64'(tlb[7][36]), 64'd1);

    // 4: global-or-asid with 4M page compare; E=0 twin must not clear
    for (int i = 0; i < 16; i++) img[i] = mk(1'b1, 10'h3FF, 1'b0, 6'd12, {10'h003, 9'h1FF});
    img[1] = mk(1'b1, 10'h3FF, 1'b1, 6'd21, {10'h003, 9'h1FF});
    img[2] = mk(1'b0, 10'h3FF, 1'b1, 6'd21, {10'h003, 9'h1FF});
    img[3] = mk(1'b1, 10'h3FF, 1'b1, 6'd12, {10'h003, 9'h1FF});
    load_img();
    run_walk("t4", 3'd6, 10'h000, 32'h00C0_0000, 16'h0002, 1, 1'b0);
    chk("t4.tlb_e1", 64'(tlb[1][36]), 64'd0);
    chk("t4.tlb_e3", 64'(tlb[3][36]), 64'd1);

    // 5: invalid op
    for (int i = 0; i < 16; i++) img[i] = mk(1'b1, 10'h0, 1'b0, 6'd12, 19'(i));
    load_img();
    run_walk("t5", 3'd7, 10'h0, 32'h0, 16'h0000, 0, 1'b1);
    chk("t5.tlb_e0", 64'(tlb[0][36]), 64'd1);

    // 6a: reset in the middle of a walk
    ifc.req_op = 3'd0; ifc.req_valid = 1'b1;
    @(negedge aclk);
    ifc.req_valid = 1'b0;
    repeat (5) @(negedge aclk);
    chk("t6.idx5",  64'(ifc.clr_idx), 64'd5);
    chk("t6.busy5", 64'(ifc.busy),    64'd1);
    areset = 1'b1;
    @(negedge aclk);
    chk("t6.rbusy",  64'(ifc.busy),      64'd0);
    chk("t6.rready", 64'(ifc.req_ready), 64'd1);
    chk("t6.rdone",  64'(ifc.done),      64'd0);
    chk("t6.rcount", 64'(ifc.clr_count), 64'd0);
    areset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      chk("t6.nodone", 64'(ifc.done), 64'd0);
    end
    chk("t6.tlb_e4", 64'(tlb[4][36]), 64'd0);
    chk("t6.tlb_e5", 64'(tlb[5][36]), 64'd1);

    // 6b: full walk, then a held request accepted right after done
    load_img();
    ifc.req_op = 3'd0; ifc.req_valid = 1'b1;
    @(negedge aclk);
    for (int i = 0; i < 16; i++) begin
      chk("t6b.ready", 64'(ifc.req_ready), 64'd0);
      chk("t6b.clren", 64'(ifc.clr_en),    64'd1);
      @(negedge aclk);
    end
    chk("t6b.done",   64'(ifc.done),      64'd1);
    chk("t6b.dready", 64'(ifc.req_ready), 64'd0);
    chk("t6b.count",  64'(ifc.clr_count), 64'd16);
    @(negedge aclk);
    chk("t6b.idle",   64'(ifc.req_ready), 64'd1);
    chk("t6b.ibusy",  64'(ifc.busy),      64'd0);
    @(negedge aclk);
    ifc.req_valid = 1'b0;
    chk("t6b.acc_busy",  64'(ifc.busy),      64'd1);
    chk("t6b.acc_idx",   64'(ifc.rd_idx),    64'd0);
    chk("t6b.acc_count", 64'(ifc.clr_count), 64'd0);
    repeat (16) @(negedge aclk);
    chk("t6b.done2",  64'(ifc.done),      64'd1);
    chk("t6b.count2", 64'(ifc.clr_count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
